// File: rtl/uart_wb_pkg.sv
// rtl/uart_wb_pkg.sv - command codes and FSM encoding shared by the UART-to-Wishbone bridge
package uart_wb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    WBUS  = 3'd4,
    RBUS  = 3'd5,
    RDATA = 3'd6
  } state_t;

endpackage

// File: rtl/uart_wb_bridge.sv
// rtl/uart_wb_bridge.sv - byte-stream command bridge to a classic Wishbone master
// Frames: cmd, N, 4 address bytes, then N big-endian words in or out.
module uart_wb_bridge
  import uart_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [31:0]           wb_dat_w,
  input  logic [31:0]           wb_dat_r,
  output logic [3:0]            wb_sel,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  input  logic                  wb_ack
);

  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_is_read;
  logic [7:0]            r_words_left;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_shift;
  logic [23:0]           r_rdat;
  logic [31:0]           r_idle_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]           r_wdat;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;

  logic        w_rx_fire;
  logic        w_tx_fire;
  logic        w_rx_phase;
  logic        w_timeout;
  logic        w_bus;
  logic        w_last_word;
  logic [31:0] w_word;

  assign w_rx_fire   = rx_valid && rx_ready;
  assign w_tx_fire   = r_tx_valid && tx_ready;
  assign w_rx_phase  = (r_state == LEN) || (r_state == ADDR) || (r_state == WDATA);
  assign w_timeout   = w_rx_phase && !w_rx_fire && (r_idle_cnt == TIMEOUT_M1);
  assign w_bus       = (r_state == WBUS) || (r_state == RBUS);
  assign w_last_word = (r_words_left == 8'd1);
  assign w_word      = {r_shift, rx_data};

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign wb_adr   = r_adr;
  assign wb_dat_w = r_wdat;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    rx_ready = !rst && (w_rx_phase || (r_state == IDLE));
    wb_cyc   = w_bus;
    wb_stb   = w_bus;
    wb_sel   = w_bus ? 4'hF : 4'h0;
    wb_we    = (r_state == WBUS);
    case (r_state)
      IDLE: begin
        if (w_rx_fire && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) w_next = LEN;
      end
      LEN: begin
        if (w_rx_fire)      w_next = ADDR;
        else if (w_timeout) w_next = IDLE;
      end
      ADDR: begin
        if (w_rx_fire && (r_byte_cnt == 2'd3)) begin
          if (r_words_left == 8'd0) w_next = IDLE;
          else if (r_is_read)       w_next = RBUS;
          else                      w_next = WDATA;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      WDATA: begin
        if (w_rx_fire && (r_byte_cnt == 2'd3)) w_next = WBUS;
        else if (w_timeout)                    w_next = IDLE;
      end
      WBUS: begin
        if (wb_ack) w_next = w_last_word ? IDLE : WDATA;
      end
      RBUS: begin
        if (wb_ack) w_next = RDATA;
      end
      RDATA: begin
        if (w_tx_fire && (r_byte_cnt == 2'd3)) w_next = w_last_word ? IDLE : RBUS;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_read    <= 1'b0;
      r_words_left <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_rdat       <= '0;
      r_idle_cnt   <= '0;
      r_adr        <= '0;
      r_wdat       <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
    end else begin
      if (w_rx_phase && !w_rx_fire) r_idle_cnt <= w_timeout ? 32'd0 : r_idle_cnt + 32'd1;
      else                          r_idle_cnt <= 32'd0;

      if (w_rx_fire) begin
        case (r_state)
          IDLE: r_is_read <= (rx_data == CMD_READ);
          LEN: begin
            r_words_left <= rx_data;
            r_byte_cnt   <= 2'd0;
          end
          ADDR, WDATA: begin
            r_shift    <= w_word[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (r_state == ADDR) r_adr  <= w_word[ADDR_WIDTH-1:0];
              else                 r_wdat <= w_word;
            end
          end
          default: ;
        endcase
      end

      // Address advances on every acked word and wraps at the bus width.
      if (w_bus && wb_ack) begin
        r_adr <= r_adr + ADDR_WIDTH'(1);
        if (r_state == WBUS) begin
          r_words_left <= r_words_left - 8'd1;
        end else begin
          r_rdat     <= wb_dat_r[23:0];
          r_tx_data  <= wb_dat_r[31:24];
          r_tx_valid <= 1'b1;
          r_byte_cnt <= 2'd0;
        end
      end

      if ((r_state == RDATA) && w_tx_fire) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0: r_tx_data <= r_rdat[23:16];
          2'd1: r_tx_data <= r_rdat[15:8];
          2'd2: r_tx_data <= r_rdat[7:0];
          default: begin
            r_tx_valid   <= 1'b0;
            r_words_left <= r_words_left - 8'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb/tb_uart_wb_bridge.sv - randomized frame bench with a queue-based frame model
module tb_uart_wb_bridge;

  localparam int AW  = 30;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat_w;
  logic [31:0]   wb_dat_r;
  logic [3:0]    wb_sel;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic          wb_ack;

  uart_wb_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
  } wb_t;

  wb_t         wb_q[$];
  wb_t         exp_wb[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] wdata_q[$];

  int            n_checks = 0;
  int            n_errors = 0;
  bit            slave_hold = 1'b0;
  bit            sink_low = 1'b0;
  bit            rd_fix_en = 1'b0;
  logic [31:0]   rd_fix = 32'h0;
  int            force_gap = -1;
  int            ack_wait = 0;
  bit            in_cyc = 1'b0;
  logic [AW-1:0] snap_adr;
  logic [31:0]   snap_dat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [AW-1:0] a);
    if (rd_fix_en) return rd_fix;
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_9617;
  endfunction

  function automatic int rgap(input int maxgap);
    if (force_gap >= 0) return force_gap;
    if (maxgap <= 0) return 0;
    if ($urandom_range(3, 0) != 0) return 0;
    return int'($urandom_range(maxgap, 0));
  endfunction

  // Wishbone slave: random ack latency, records every acked access.
  always @(negedge clk) begin
    if (!wb_cyc) in_cyc = 1'b0;
    if (wb_ack) begin
      wb_ack = 1'b0;
    end else if (wb_cyc && wb_stb && !slave_hold) begin
      if (!in_cyc) begin
        in_cyc   = 1'b1;
        snap_adr = wb_adr;
        snap_dat = wb_dat_w;
      end
      if (ack_wait == 0) begin
        check("wb_adr_stable", 64'(wb_adr), 64'(snap_adr));
        check("wb_dat_stable", 64'(wb_dat_w), 64'(snap_dat));
        wb_dat_r = wb_we ? 32'h0 : rd_val(wb_adr);
        wb_ack   = 1'b1;
        wb_q.push_back('{we: wb_we, sel: wb_sel, adr: wb_adr, dat: (wb_we ? wb_dat_w : wb_dat_r)});
        ack_wait = int'($urandom_range(3, 0));
      end else begin
        ack_wait--;
      end
    end
  end

  // Byte sink: random backpressure; a byte is taken at the next posedge when valid and ready.
  always @(negedge clk) begin
    tx_ready = sink_low ? 1'b0 : ($urandom_range(1, 0) == 1);
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    while (!rx_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) check("rx_ready_wait", 64'(rx_ready), 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] n,
                            input logic [31:0] addr, input int maxgap);
    logic [31:0]   w;
    logic [AW-1:0] a;
    send_byte(cmd, rgap(maxgap));
    if (cmd != 8'h01 && cmd != 8'h02) return;
    send_byte(n, rgap(maxgap));
    for (int k = 0; k < 4; k++) send_byte(addr[31-8*k -: 8], rgap(maxgap));
    for (int i = 0; i < int'(n); i++) begin
      a = addr[AW-1:0] + AW'(i);
      if (cmd == 8'h01) begin
        w = (wdata_q.size() > 0) ? wdata_q.pop_front() : $urandom;
        exp_wb.push_back('{we: 1'b1, sel: 4'hF, adr: a, dat: w});
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], rgap(maxgap));
      end else begin
        w = rd_val(a);
        exp_wb.push_back('{we: 1'b0, sel: 4'hF, adr: a, dat: w});
        for (int k = 0; k < 4; k++) exp_tx.push_back(w[31-8*k -: 8]);
      end
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(rx_ready && !wb_cyc && !tx_valid && wb_q.size() == exp_wb.size()
                 && tx_q.size() == exp_tx.size()) && guard < 5000);
    if (guard >= 5000) check("frame_done_wait", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_wb_count"}, 64'(wb_q.size()), 64'(exp_wb.size()));
    for (int i = 0; i < exp_wb.size() && i < wb_q.size(); i++) begin
      check({tag, "_we"},  64'(wb_q[i].we),  64'(exp_wb[i].we));
      check({tag, "_sel"}, 64'(wb_q[i].sel), 64'(exp_wb[i].sel));
      check({tag, "_adr"}, 64'(wb_q[i].adr), 64'(exp_wb[i].adr));
      check({tag, "_dat"}, 64'(wb_q[i].dat), 64'(exp_wb[i].dat));
    end
    check({tag, "_tx_count"}, 64'(tx_q.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check({tag, "_tx_byte"}, 64'(tx_q[i]), 64'(exp_tx[i]));
    wb_q.delete();
    exp_wb.delete();
    tx_q.delete();
    exp_tx.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    bit          held;
    int          guard;
    int          sel;
    logic [7:0]  cmd;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; wb_ack = 1'b0; wb_dat_r = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready",  64'(rx_ready), 64'd0);
    check("rst_tx_valid",  64'(tx_valid), 64'd0);
    check("rst_tx_data",   64'(tx_data),  64'd0);
    check("rst_wb_cyc",    64'(wb_cyc),   64'd0);
    check("rst_wb_stb",    64'(wb_stb),   64'd0);
    check("rst_wb_we",     64'(wb_we),    64'd0);
    check("rst_wb_sel",    64'(wb_sel),   64'd0);
    check("rst_wb_adr",    64'(wb_adr),   64'd0);
    check("rst_wb_dat_w",  64'(wb_dat_w), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 64'(rx_ready), 64'd1);

    wdata_q.push_back(32'h0000_000E);
    send_frame(8'h01, 8'd1, 32'h0000_2400, 0);
    wait_done();
    compare_all("wr_basic");

    rd_fix_en = 1'b1;
    rd_fix    = 32'h1234_5678;
    send_frame(8'h02, 8'd1, 32'h0400_0000, 0);
    wait_done();
    compare_all("rd_basic");
    rd_fix_en = 1'b0;

    send_frame(8'h01, 8'd2, 32'h3FFF_FFFF, 0);
    wait_done();
    compare_all("wr_wrap");

    send_byte(8'h7F, 0);
    send_frame(8'h01, 8'd1, $urandom, 0);
    wait_done();
    compare_all("bad_cmd");

    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    repeat (TMO) @(posedge clk);
    send_frame(8'h01, 8'd1, $urandom, 0);
    wait_done();
    compare_all("timeout");

    force_gap = TMO - 1;
    send_frame(8'h01, 8'd2, $urandom, 0);
    force_gap = -1;
    wait_done();
    compare_all("gap_max");

    send_frame(8'h01, 8'd0, $urandom, 0);
    send_frame(8'h02, 8'd0, $urandom, 0);
    wait_done();
    compare_all("len_zero");

    for (int f = 0; f < 25; f++) begin
      sel = int'($urandom_range(9, 0));
      if (sel == 0)     cmd = 8'(3 + $urandom_range(250, 0));
      else if (sel < 5) cmd = 8'h01;
      else              cmd = 8'h02;
      send_frame(cmd, 8'($urandom_range(4, 0)), $urandom, TMO - 1);
      wait_done();
      compare_all("random");
    end

    rd_fix_en = 1'b1;
    rd_fix    = 32'h1234_5678;
    sink_low  = 1'b1;
    send_frame(8'h02, 8'd1, $urandom, 0);
    guard = 0;
    while (!tx_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    held = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!(tx_valid && tx_data == 8'h12)) held = 1'b0;
    end
    check("tx_hold_stable", 64'(held), 64'd1);
    check("tx_hold_data", 64'(tx_data), 64'h12);
    sink_low = 1'b0;
    wait_done();
    compare_all("tx_backpressure");
    rd_fix_en = 1'b0;

    slave_hold = 1'b1;
    send_frame(8'h01, 8'd1, $urandom, 0);
    guard = 0;
    while (!wb_cyc && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("wbus_cyc", 64'(wb_cyc), 64'd1);
    check("wbus_we",  64'(wb_we),  64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_wb_cyc", 64'(wb_cyc), 64'd0);
    check("abort_wb_stb", 64'(wb_stb), 64'd0);
    check("abort_wb_sel", 64'(wb_sel), 64'd0);
    check("abort_rx_ready", 64'(rx_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    slave_hold = 1'b0;
    check("abort_wb_adr", 64'(wb_adr), 64'd0);
    check("abort_no_access", 64'(wb_q.size()), 64'd0);
    exp_wb.delete();
    send_frame(8'h01, 8'd1, $urandom, 0);
    wait_done();
    compare_all("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_wb_bridge.md
UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, Wishbone word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 100000, inter-byte idle cycles before a partial frame is abandoned.
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  in  8  byte from UART receiver.
REQ-006 SHALL have port rx_valid  in  1  rx_data valid.
REQ-007 SHALL have port rx_ready  out  1  bridge accepts rx_data this cycle.
REQ-008 SHALL have port tx_data  out  8  byte to UART transmitter.
REQ-009 SHALL have port tx_valid  out  1  tx_data valid.
REQ-010 SHALL have port tx_ready  in  1  transmitter accepts tx_data.
REQ-011 SHALL have ports wb_adr out ADDR_WIDTH, wb_dat_w out 32, wb_dat_r in 32, wb_sel out 4, wb_cyc out 1, wb_stb out 1, wb_we out 1, wb_ack in 1: classic Wishbone master.

Function
REQ-012 Frame SHALL be: cmd byte, length byte N, 4 address bytes MSB first, then N 32-bit words MSB first (write: host to bridge; read: bridge to host).
REQ-013 cmd 0x01 SHALL be write, 0x02 read; any other cmd byte SHALL be consumed and discarded, staying in IDLE.
REQ-014 FSM states SHALL be IDLE, LEN, ADDR, WDATA, WBUS, RBUS, RDATA.
REQ-015 Transitions: IDLE->LEN on valid cmd; LEN->ADDR; ADDR->(N=0: IDLE; write: WDATA; read: RBUS) after 4th byte; WDATA->WBUS after 4th byte; WBUS->(WDATA, or IDLE after word N) on ack; RBUS->RDATA on ack; RDATA->(RBUS, or IDLE after word N) after 4th byte accepted.
REQ-016 rx byte consumed iff rx_valid and rx_ready; rx_ready SHALL be 1 only in IDLE, LEN, ADDR, WDATA.
REQ-017 wb_adr SHALL equal received address[ADDR_WIDTH-1:0], incremented by 1 after each acked word, wrapping modulo 2^ADDR_WIDTH.
REQ-018 In WBUS/RBUS: wb_cyc=wb_stb=1, wb_sel=4'hF, wb_we=1 in WBUS else 0; held stable until wb_ack; cyc/stb drop the cycle after ack.
REQ-019 Read data SHALL be latched on the ack cycle; tx_data/tx_valid SHALL stay stable until tx_ready; bytes sent [31:24] first.
REQ-020 Bus access SHALL begin the cycle after the 4th data byte (write) or address byte (read); no bus timeout.
REQ-021 In LEN, ADDR, WDATA, an idle counter SHALL count cycles without an accepted byte; reaching TIMEOUT returns to IDLE with no bus access; counter clears on each accepted byte.
REQ-022 Timeout SHALL NOT apply in WBUS, RBUS, RDATA.
REQ-023 N=0 SHALL perform no bus access and send no bytes.

Reset
REQ-024 On rst: state IDLE; rx_ready=0 that cycle then 1 in IDLE; tx_valid=0; tx_data=0; wb_cyc=wb_stb=wb_we=0; wb_sel=0; wb_adr=0; wb_dat_w=0; counters 0.
REQ-025 rst mid-frame or mid-bus-cycle SHALL abort immediately, dropping cyc/stb and tx_valid next cycle.

Structure
REQ-026 Command codes (0x01, 0x02) and state encoding SHALL live in shared package uart_wb_pkg.
REQ-027 Single module; byte shifter and word counter inline; no sub-module required.

Verification
REQ-028 Bytes 01 01 00 00 24 00 00 00 00 0E -> one Wishbone write adr 0x2400 dat 0x0000000E sel 0xF we=1.
REQ-029 Bytes 02 01 04 00 00 00, wb_dat_r=0x12345678 on ack -> tx 12 34 56 78 in order.
REQ-030 Write N=2 at 0x3FFFFFFF -> writes to adr 0x3FFFFFFF then 0x00000000.
REQ-031 Byte 0x7F then valid write frame -> 0x7F ignored, write frame executes normally.
REQ-032 Bytes 01 01 00 then TIMEOUT idle cycles -> IDLE, no wb_cyc; following frame executes.
REQ-033 Read with tx_ready low 50 cycles -> tx_data held 0x12 stable; rst asserted in WBUS -> wb_cyc=0 next cycle.
